// File: rtl/qcw_pkg.sv
// Shared types and elaboration-time helpers for the QCW overcurrent detector.
package qcw_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRIPPED = 2'd2,
    HOLDOFF = 2'd3
  } ocd_state_t;

  function automatic int midscale(input int adc_w);
    return 1 << (adc_w - 1);
  endfunction

  // Bits needed to hold values 0..n inclusive (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/qcw_ocd_chan.sv
// One current channel: IIR low-pass, |y - midscale|, per-pulse peak and
// consecutive over-limit counter. at_limit flags the sample that completes a run.
module qcw_ocd_chan
  import qcw_pkg::*;
#(
  parameter int ADC_W        = 10,
  parameter int FRAC_W       = 8,
  parameter int FILTER_SHIFT = 1,
  parameter int OCD_LIMIT    = 400,
  parameter int TRIP_COUNT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             adc_valid,
  input  logic             eval,
  input  logic             armed,
  input  logic [ADC_W-1:0] x,
  output logic [ADC_W-1:0] peak,
  output logic             at_limit
);

  localparam int ACC_W = ADC_W + FRAC_W;
  localparam int CW    = cnt_w(TRIP_COUNT);
  localparam logic [ADC_W-1:0] MID  = ADC_W'(midscale(ADC_W));
  localparam logic [ADC_W:0]   LIM  = (ADC_W+1)'(OCD_LIMIT);
  localparam logic [CW:0]      TRIP = (CW+1)'(TRIP_COUNT);
  localparam logic signed [ACC_W:0] FILT_RST =
    $signed((ACC_W+1)'(midscale(ADC_W) << FRAC_W));

  // Filter state carries one spare sign bit so the update stays in signed arithmetic.
  logic signed [ACC_W:0] filt;
  logic signed [ACC_W:0] diff;
  logic signed [ACC_W:0] step;
  logic [ADC_W-1:0]      y_int;
  logic [ADC_W-1:0]      mag;
  logic                  over;
  logic [CW-1:0]         cnt;
  logic [CW:0]           cnt_inc;

  assign diff    = $signed({1'b0, x, {FRAC_W{1'b0}}}) - filt;
  assign step    = diff >>> FILTER_SHIFT;
  assign y_int   = filt[ACC_W-1:FRAC_W];
  assign mag     = (y_int >= MID) ? (y_int - MID) : (MID - y_int);
  assign over    = {1'b0, mag} > LIM;
  assign cnt_inc = {1'b0, cnt} + (CW+1)'(1);
  assign at_limit = eval && armed && over && (cnt_inc >= TRIP);

  // Stage p0: filter update on every valid sample, regardless of detector state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= FILT_RST;
    end else if (adc_valid) begin
      filt <= filt + step;
    end
  end

  // Stage p1: peak and run counter, evaluated one edge after the filter update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak <= '0;
      cnt  <= '0;
    end else begin
      if (start) begin
        peak <= '0;
      end else if (eval && (mag > peak)) begin
        peak <= mag;
      end

      if (!armed) begin
        cnt <= '0;
      end else if (eval) begin
        if (!over) begin
          cnt <= '0;
        end else if (cnt_inc >= TRIP) begin
          cnt <= TRIP[CW-1:0];
        end else begin
          cnt <= cnt_inc[CW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/qcw_ocd_mc.sv
// Multi-channel QCW overcurrent detector: per-channel detectors plus the
// trip/holdoff state machine that drives qcw_halt and reports faulting channels.
module qcw_ocd_mc
  import qcw_pkg::*;
#(
  parameter int N_CH           = 2,
  parameter int ADC_W          = 10,
  parameter int FRAC_W         = 8,
  parameter int FILTER_SHIFT   = 1,
  parameter int OCD_LIMIT      = 400,
  parameter int TRIP_COUNT     = 2,
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int LATCH_FAULT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  enable,
  input  logic                  clear_fault,
  input  logic                  adc_valid,
  input  logic [N_CH*ADC_W-1:0] adc_dout,
  output logic [N_CH*ADC_W-1:0] current_max,
  output logic                  qcw_halt,
  output logic [N_CH-1:0]       fault_ch,
  output logic [1:0]            ocd_state
);

  localparam int HW = cnt_w(HOLDOFF_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

  ocd_state_t      state, state_next;
  logic            eval;
  logic            armed;
  logic            trip;
  logic [N_CH-1:0] at_limit;
  logic [HW-1:0]   hold_cnt, hold_cnt_next;
  logic            halt_next;
  logic [N_CH-1:0] fault_next;

  assign armed     = (state == ARMED);
  assign trip      = |at_limit;
  assign ocd_state = state;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    qcw_ocd_chan #(
      .ADC_W        (ADC_W),
      .FRAC_W       (FRAC_W),
      .FILTER_SHIFT (FILTER_SHIFT),
      .OCD_LIMIT    (OCD_LIMIT),
      .TRIP_COUNT   (TRIP_COUNT)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .adc_valid (adc_valid),
      .eval      (eval),
      .armed     (armed),
      .x         (adc_dout[c*ADC_W +: ADC_W]),
      .peak      (current_max[c*ADC_W +: ADC_W]),
      .at_limit  (at_limit[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      eval     <= 1'b0;
      hold_cnt <= '0;
      qcw_halt <= 1'b0;
      fault_ch <= '0;
    end else begin
      state    <= state_next;
      eval     <= adc_valid;
      hold_cnt <= hold_cnt_next;
      qcw_halt <= halt_next;
      fault_ch <= fault_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = ARMED;
      // A completed trip takes priority over disarming on the same edge.
      ARMED: begin
        if (trip)         state_next = TRIPPED;
        else if (!enable) state_next = IDLE;
      end
      TRIPPED: begin
        if ((LATCH_FAULT == 0) || clear_fault) state_next = HOLDOFF;
      end
      HOLDOFF: begin
        if (hold_cnt == HOLD_LAST) state_next = enable ? ARMED : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    halt_next     = (state_next == TRIPPED) || (state_next == HOLDOFF);
    hold_cnt_next = '0;
    fault_next    = fault_ch;
    if ((state == HOLDOFF) && (state_next == HOLDOFF)) begin
      hold_cnt_next = hold_cnt + HW'(1);
    end
    if ((state == ARMED) && (state_next == TRIPPED)) begin
      fault_next = at_limit;
    end else if ((state == HOLDOFF) && (state_next != HOLDOFF)) begin
      fault_next = '0;
    end
  end

endmodule

// File: tb/tb_qcw_ocd_mc.sv
// Directed bench for qcw_ocd_mc: an auto-release instance and a latched-fault instance share stimulus.
module tb_qcw_ocd_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        enable = 1'b0;
  logic        clear_fault = 1'b0;
  logic        adc_valid = 1'b0;
  logic [19:0] adc_dout = {10'd512, 10'd512};

  logic [19:0] cmax0, cmax1;
  logic        halt0, halt1;
  logic [1:0]  fault0, fault1;
  logic [1:0]  st0, st1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  qcw_ocd_mc u_dut0 (
    .clk(clk), .rst(rst), .start(start), .enable(enable), .clear_fault(clear_fault),
    .adc_valid(adc_valid), .adc_dout(adc_dout), .current_max(cmax0),
    .qcw_halt(halt0), .fault_ch(fault0), .ocd_state(st0)
  );

  qcw_ocd_mc #(.LATCH_FAULT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .enable(enable), .clear_fault(clear_fault),
    .adc_valid(adc_valid), .adc_dout(adc_dout), .current_max(cmax1),
    .qcw_halt(halt1), .fault_ch(fault1), .ocd_state(st1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    start = 1'b0; enable = 1'b0; clear_fault = 1'b0; adc_valid = 1'b0;
    adc_dout = {10'd512, 10'd512};
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  // Arms the detector then feeds four samples; the trip lands on the next edge.
  task automatic arm_and_feed4(input logic [9:0] x0, input logic [9:0] x1);
    enable = 1'b1;
    step();
    adc_dout = {x1, x0};
    adc_valid = 1'b1;
    repeat (4) step();
    adc_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (halt0 !== 1'b0) $display("FAIL reset_halt: got %0b expected 0", halt0); else passes++;
    checks++; if (st0 !== 2'd0) $display("FAIL reset_state: got %0d expected 0", st0); else passes++;
    checks++; if (fault0 !== 2'b00) $display("FAIL reset_fault: got %b expected 00", fault0); else passes++;
    checks++; if (cmax0 !== 20'd0) $display("FAIL reset_cmax: got %h expected 0", cmax0); else passes++;
    checks++; if (st1 !== 2'd0) $display("FAIL reset_state_latch: got %0d expected 0", st1); else passes++;
    checks++; if (u_dut0.g_ch[0].u_chan.filt !== 19'sd131072)
      $display("FAIL reset_filter: got %0d expected 131072", u_dut0.g_ch[0].u_chan.filt); else passes++;
  endtask

  task automatic test_trip_auto();
    apply_reset();
    enable = 1'b1;
    step();
    checks++; if (st0 !== 2'd1) $display("FAIL auto_armed: state %0d expected 1", st0); else passes++;
    adc_dout = {10'd512, 10'd1023};
    adc_valid = 1'b1;
    repeat (3) step();
    checks++; if (cmax0[9:0] !== 10'd383) $display("FAIL auto_mag2: got %0d expected 383", cmax0[9:0]); else passes++;
    step();
    adc_valid = 1'b0;
    checks++; if (cmax0[9:0] !== 10'd447) $display("FAIL auto_mag3: got %0d expected 447", cmax0[9:0]); else passes++;
    checks++; if (halt0 !== 1'b0) $display("FAIL auto_halt_early: got %0b expected 0", halt0); else passes++;
    step();
    checks++; if (halt0 !== 1'b1) $display("FAIL auto_halt: got %0b expected 1", halt0); else passes++;
    checks++; if (st0 !== 2'd2) $display("FAIL auto_tripped: state %0d expected 2", st0); else passes++;
    checks++; if (fault0 !== 2'b01) $display("FAIL auto_fault: got %b expected 01", fault0); else passes++;
    checks++; if (cmax0[9:0] !== 10'd479) $display("FAIL auto_mag4: got %0d expected 479", cmax0[9:0]); else passes++;
    step();
    checks++; if (st0 !== 2'd3) $display("FAIL auto_holdoff: state %0d expected 3", st0); else passes++;
    repeat (999) step();
    checks++; if (st0 !== 2'd3 || halt0 !== 1'b1)
      $display("FAIL auto_hold_last: state %0d halt %0b expected 3/1", st0, halt0); else passes++;
    step();
    checks++; if (st0 !== 2'd1 || halt0 !== 1'b0)
      $display("FAIL auto_release: state %0d halt %0b expected 1/0", st0, halt0); else passes++;
    checks++; if (fault0 !== 2'b00) $display("FAIL auto_fault_clr: got %b expected 00", fault0); else passes++;
  endtask

  task automatic test_no_trip_peak();
    logic [9:0] seq [6] = '{10'd1023, 10'd512, 10'd1023, 10'd512, 10'd1023, 10'd512};
    apply_reset();
    enable = 1'b1;
    step();
    adc_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      adc_dout = {seq[i], 10'd512};
      step();
    end
    adc_valid = 1'b0;
    step();
    checks++; if (st0 !== 2'd1 || halt0 !== 1'b0)
      $display("FAIL alt_no_trip: state %0d halt %0b expected 1/0", st0, halt0); else passes++;
    checks++; if (cmax0[19:10] !== 10'd335) $display("FAIL alt_peak_ch1: got %0d expected 335", cmax0[19:10]); else passes++;
    checks++; if (cmax0[9:0] !== 10'd0) $display("FAIL alt_peak_ch0: got %0d expected 0", cmax0[9:0]); else passes++;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (cmax0 !== 20'd0) $display("FAIL start_clear: got %h expected 0", cmax0); else passes++;
  endtask

  task automatic test_latched();
    apply_reset();
    arm_and_feed4(10'd1023, 10'd512);
    step();
    checks++; if (st1 !== 2'd2 || halt1 !== 1'b1)
      $display("FAIL latch_trip: state %0d halt %0b expected 2/1", st1, halt1); else passes++;
    enable = 1'b0;
    repeat (50) step();
    checks++; if (st1 !== 2'd2 || halt1 !== 1'b1)
      $display("FAIL latch_hold: state %0d halt %0b expected 2/1", st1, halt1); else passes++;
    checks++; if (st0 !== 2'd3) $display("FAIL auto_in_holdoff: state %0d expected 3", st0); else passes++;
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    checks++; if (st1 !== 2'd3 || halt1 !== 1'b1)
      $display("FAIL latch_clear: state %0d halt %0b expected 3/1", st1, halt1); else passes++;
    checks++; if (st0 !== 2'd3) $display("FAIL clear_ignored: state %0d expected 3", st0); else passes++;
    enable = 1'b1;
    repeat (999) step();
    checks++; if (st1 !== 2'd3) $display("FAIL latch_hold_last: state %0d expected 3", st1); else passes++;
    step();
    checks++; if (st1 !== 2'd1 || halt1 !== 1'b0)
      $display("FAIL latch_release: state %0d halt %0b expected 1/0", st1, halt1); else passes++;
  endtask

  task automatic test_dual_trip();
    apply_reset();
    enable = 1'b1;
    step();
    adc_dout = {10'd0, 10'd0};
    adc_valid = 1'b1;
    repeat (3) step();
    checks++; if (cmax0 !== {10'd384, 10'd384}) $display("FAIL dual_mag2: got %h expected %h", cmax0, {10'd384, 10'd384}); else passes++;
    step();
    adc_valid = 1'b0;
    checks++; if (cmax0 !== {10'd448, 10'd448}) $display("FAIL dual_mag3: got %h expected %h", cmax0, {10'd448, 10'd448}); else passes++;
    step();
    checks++; if (halt0 !== 1'b1 || fault0 !== 2'b11)
      $display("FAIL dual_trip: halt %0b fault %b expected 1/11", halt0, fault0); else passes++;
    checks++; if (cmax0 !== {10'd480, 10'd480}) $display("FAIL dual_mag4: got %h expected %h", cmax0, {10'd480, 10'd480}); else passes++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    arm_and_feed4(10'd1023, 10'd512);
    repeat (3) step();
    checks++; if (st0 !== 2'd3) $display("FAIL ar_pre_state: got %0d expected 3", st0); else passes++;
    #3;
    rst = 1'b1;
    #1;
    checks++; if (halt0 !== 1'b0 || st0 !== 2'd0)
      $display("FAIL ar_immediate: halt %0b state %0d expected 0/0", halt0, st0); else passes++;
    checks++; if (u_dut0.g_ch[0].u_chan.filt !== 19'sd131072)
      $display("FAIL ar_filter: got %0d expected 131072", u_dut0.g_ch[0].u_chan.filt); else passes++;
    checks++; if (fault0 !== 2'b00 || cmax0 !== 20'd0)
      $display("FAIL ar_outputs: fault %b cmax %h expected 00/0", fault0, cmax0); else passes++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_enable_race();
    apply_reset();
    arm_and_feed4(10'd1023, 10'd512);
    enable = 1'b0;
    step();
    checks++; if (st0 !== 2'd2 || halt0 !== 1'b1)
      $display("FAIL race_trip_wins: state %0d halt %0b expected 2/1", st0, halt0); else passes++;
    apply_reset();
    enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    checks++; if (st0 !== 2'd0) $display("FAIL disarm_idle: state %0d expected 0", st0); else passes++;
    adc_dout = {10'd512, 10'd1023};
    adc_valid = 1'b1;
    repeat (6) step();
    adc_valid = 1'b0;
    step();
    checks++; if (st0 !== 2'd0 || halt0 !== 1'b0)
      $display("FAIL idle_ignores: state %0d halt %0b expected 0/0", st0, halt0); else passes++;
    enable = 1'b1;
    step();
    adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
    step();
    checks++; if (st0 !== 2'd1 || halt0 !== 1'b0)
      $display("FAIL rearm_single: state %0d halt %0b expected 1/0", st0, halt0); else passes++;
  endtask

  initial begin
    test_reset();
    test_trip_auto();
    test_no_trip_peak();
    test_latched();
    test_dual_trip();
    test_async_reset();
    test_enable_race();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
